reg_context_engine: RTL and testbench

Sequencer that drives the register file's read and write ports to move the whole register set to or from data memory.
- Save: reads registers and writes them to memory.
- Restore: reads memory and writes registers.
- Sits between the control unit (start/done), the Register_File access ports and the data-memory request port; used for interrupt entry/exit and context switch.

---
 rtl/ctx_pkg.sv | 33 +++
 rtl/reg_context_engine.sv | 147 ++++++++++++++
 tb/tb_reg_context_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctx_pkg.sv
// Shared types and constants for the register context save/restore engine.
// Build option: define CTX_SKIP_R0_EN to leave register 0 out of every transfer.
package ctx_pkg;

  localparam int NUM_REGS  = 8;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 16;
  localparam int ADDR_STEP = 2;
  localparam int MEM_AW    = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE       = 3'd1,
    RESTORE_RD = 3'd2,
    RESTORE_WR = 3'd3,
    DONE       = 3'd4
  } ctx_state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef CTX_SKIP_R0_EN
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(0);
`endif

  // Memory slot for a register; wraps silently past 0xFFFF.
  function automatic logic [MEM_AW-1:0] slot_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [ADDR_W-1:0] idx);
    return base + (MEM_AW'(idx) * MEM_AW'(ADDR_STEP));
  endfunction

endpackage

// File: rtl/reg_context_engine.sv
// Moves the register set between the register file and data memory (save / restore).
// Build option: CTX_SKIP_R0_EN (see ctx_pkg) starts every transfer at register 1.
module reg_context_engine
  import ctx_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start_save,
  input  logic              Start_restore,
  input  logic [MEM_AW-1:0] Base_addr,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Reg_rd_addr,
  input  logic [DATA_W-1:0] Reg_rd_data,
  output logic [ADDR_W-1:0] Reg_wr_addr,
  output logic [DATA_W-1:0] Reg_wr_data,
  output logic              Reg_Write,
  output logic              Mem_req,
  output logic              Mem_we,
  output logic [MEM_AW-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_wdata,
  input  logic [DATA_W-1:0] Mem_rdata,
  input  logic              Mem_ready
);

  ctx_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  // Next-state logic; outputs are decoded from the next state so they leave flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (Start_save) begin
          state_d = SAVE;
          base_d  = Base_addr;
          idx_d   = FIRST_IDX;
        end else if (Start_restore) begin
          state_d = RESTORE_RD;
          base_d  = Base_addr;
          idx_d   = FIRST_IDX;
        end else begin
          state_d = IDLE;
        end
      end
      SAVE: begin
        if (!Mem_ready) begin
          state_d = SAVE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      RESTORE_RD: begin
        if (Mem_ready) begin
          hold_d  = Mem_rdata;
          state_d = RESTORE_WR;
        end else begin
          state_d = RESTORE_RD;
        end
      end
      RESTORE_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RESTORE_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == SAVE) || (state_d == RESTORE_RD) || (state_d == RESTORE_WR);
    done_d      = (state_d == DONE);
    mem_req_d   = (state_d == SAVE) || (state_d == RESTORE_RD);
    mem_we_d    = (state_d == SAVE);
    reg_write_d = (state_d == RESTORE_WR);
    mem_addr_d  = mem_req_d   ? slot_addr(base_d, idx_d) : {MEM_AW{1'b0}};
    rd_addr_d   = mem_we_d    ? idx_d  : {ADDR_W{1'b0}};
    wr_addr_d   = reg_write_d ? idx_d  : {ADDR_W{1'b0}};
    wr_data_d   = reg_write_d ? hold_d : {DATA_W{1'b0}};
  end

  // State, datapath and output registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      idx_q       <= {ADDR_W{1'b0}};
      base_q      <= {MEM_AW{1'b0}};
      hold_q      <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reg_write_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      rd_addr_q   <= {ADDR_W{1'b0}};
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      mem_addr_q  <= {MEM_AW{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      reg_write_q <= reg_write_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Reg_Write   = reg_write_q;
  assign Mem_req     = mem_req_q;
  assign Mem_we      = mem_we_q;
  assign Mem_addr    = mem_addr_q;
  assign Reg_rd_addr = rd_addr_q;
  assign Reg_wr_addr = wr_addr_q;
  assign Reg_wr_data = wr_data_q;
  // Save data flows straight from the register file read port to memory.
  assign Mem_wdata   = mem_we_q ? Reg_rd_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_reg_context_engine.sv
// Self-checking bench for reg_context_engine: register-file and memory models plus scenario tasks.
module tb_reg_context_engine;

`ifdef CTX_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NR = 8;
  localparam int NX = NR - FIRST;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Start_save = 1'b0;
  logic        Start_restore = 1'b0;
  logic [15:0] Base_addr = 16'h0000;
  logic        Busy, Done, Reg_Write, Mem_req, Mem_we, Mem_ready;
  logic [2:0]  Reg_rd_addr, Reg_wr_addr;
  logic [15:0] Reg_rd_data, Reg_wr_data, Mem_addr, Mem_wdata, Mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] regs [NR];
  logic [15:0] mem [65536];
  logic        load_regs = 1'b0;
  logic [15:0] init_regs [NR];
  logic        load_mem = 1'b0;
  logic [15:0] ld_base = 16'h0000;
  logic [15:0] init_mem [NR];
  int          wcnt = 0;
  int          lat = 0;
  logic [15:0] wlog_addr [$];
  logic [15:0] wlog_data [$];

  reg_context_engine dut (
    .CLK(CLK), .Reset(Reset), .Start_save(Start_save), .Start_restore(Start_restore),
    .Base_addr(Base_addr), .Busy(Busy), .Done(Done),
    .Reg_rd_addr(Reg_rd_addr), .Reg_rd_data(Reg_rd_data),
    .Reg_wr_addr(Reg_wr_addr), .Reg_wr_data(Reg_wr_data), .Reg_Write(Reg_Write),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Mem_rdata(Mem_rdata), .Mem_ready(Mem_ready)
  );

  always #5 CLK = ~CLK;

  assign Reg_rd_data = regs[Reg_rd_addr];
  assign Mem_rdata   = mem[Mem_addr];
  assign Mem_ready   = (wcnt >= lat);

  always @(posedge CLK) begin
    if (load_regs) begin
      for (int i = 0; i < NR; i++) regs[i] <= init_regs[i];
    end else if (Reg_Write) begin
      regs[Reg_wr_addr] <= Reg_wr_data;
    end
    if (load_mem) begin
      for (int i = 0; i < NR; i++) mem[ld_base + 16'(2 * i)] <= init_mem[i];
    end else if (Mem_req && Mem_ready && Mem_we) begin
      mem[Mem_addr] <= Mem_wdata;
      wlog_addr.push_back(Mem_addr);
      wlog_data.push_back(Mem_wdata);
    end
    if (Mem_req && !Mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic load_reg_file(input bit rnd, input logic [15:0] pat);
    for (int i = 0; i < NR; i++) init_regs[i] = rnd ? 16'($urandom) : pat + 16'(i);
    load_regs = 1'b1;
    @(posedge CLK); #1;
    load_regs = 1'b0;
  endtask

  task automatic load_memory(input logic [15:0] base, input bit rnd, input logic [15:0] pat);
    ld_base = base;
    for (int i = 0; i < NR; i++) init_mem[i] = rnd ? 16'($urandom) : pat + 16'(i);
    load_mem = 1'b1;
    @(posedge CLK); #1;
    load_mem = 1'b0;
  endtask

  // Pulse a start, then observe every cycle until Done (bounded); counts only, no verdicts.
  task automatic run_op(input bit do_save, input bit do_rest, input logic [15:0] base,
                        input int inject_at, output int cycles, output bit timed_out,
                        output int busy_drops, output int regwr_seen, output int rd_seen,
                        output int unstable);
    bit prev_wait;
    logic [15:0] paddr;
    logic pwe;
    Start_save = do_save; Start_restore = do_rest; Base_addr = base;
    cycles = 0; timed_out = 1'b1; busy_drops = 0; regwr_seen = 0; rd_seen = 0; unstable = 0;
    prev_wait = 1'b0; paddr = 16'h0000; pwe = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK); #1;
      cycles++;
      if (c == 0) begin
        Start_save = 1'b0; Start_restore = 1'b0; Base_addr = 16'($urandom);
      end
      if (c == inject_at) Start_restore = 1'b1;
      else if (c == inject_at + 1) Start_restore = 1'b0;
      if (Done) begin timed_out = 1'b0; break; end
      if (!Busy) busy_drops++;
      if (Reg_Write) regwr_seen++;
      if (Mem_req && !Mem_we) rd_seen++;
      if (prev_wait && (!Mem_req || Mem_addr !== paddr || Mem_we !== pwe)) unstable++;
      prev_wait = Mem_req && !Mem_ready; paddr = Mem_addr; pwe = Mem_we;
    end
    Start_restore = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({Busy, Done, Reg_Write, Mem_req, Mem_we, Reg_rd_addr, Reg_wr_addr, Reg_wr_data,
         Mem_addr, Mem_wdata} !== 59'd0) begin
      errors++; $display("FAIL reset_outputs: Busy=%b Done=%b Mem_req=%b Reg_Write=%b, required all 0",
                         Busy, Done, Mem_req, Reg_Write);
    end
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (Busy !== 1'b0 || Mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: Busy=%b Mem_req=%b, required 0 0", Busy, Mem_req);
    end
  endtask

  task automatic test_save(input logic [15:0] base, input int lat_in, input bit rnd);
    int cyc, bd, rw, rd, us, n0, exp_cyc;
    bit to;
    logic [15:0] ea;
    lat = lat_in;
    load_reg_file(rnd, 16'h1000);
    n0 = wlog_addr.size();
    run_op(1'b1, 1'b0, base, -1, cyc, to, bd, rw, rd, us);
    exp_cyc = 1 + NX * (lat_in + 1);
    checks++;
    if (to || cyc !== exp_cyc) begin
      errors++; $display("FAIL save_latency base=%h: cycles=%0d timeout=%b, required %0d", base, cyc, to, exp_cyc);
    end
    checks++;
    if (bd !== 0 || rw !== 0 || rd !== 0 || us !== 0) begin
      errors++; $display("FAIL save_signals: busy_drops=%0d regwrites=%0d reads=%0d unstable=%0d, required 0",
                         bd, rw, rd, us);
    end
    checks++;
    if (wlog_addr.size() - n0 !== NX) begin
      errors++; $display("FAIL save_count: writes=%0d, required %0d", wlog_addr.size() - n0, NX);
    end else begin
      for (int k = 0; k < NX; k++) begin
        ea = base + 16'(2 * (FIRST + k));
        checks++;
        if (wlog_addr[n0 + k] !== ea || wlog_data[n0 + k] !== init_regs[FIRST + k]) begin
          errors++; $display("FAIL save_word%0d: addr=%h data=%h, required addr=%h data=%h", k,
                             wlog_addr[n0 + k], wlog_data[n0 + k], ea, init_regs[FIRST + k]);
        end
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL save_done_pulse: Done=%b Busy=%b, required 0 0", Done, Busy);
    end
  endtask

  task automatic test_restore(input logic [15:0] base, input int lat_in, input bit rnd);
    int cyc, bd, rw, rd, us, n0, exp_cyc;
    bit to;
    logic [15:0] pre [NR];
    logic [15:0] exp_v;
    lat = lat_in;
    load_reg_file(1'b1, 16'h0000);
    load_memory(base, rnd, 16'hA0A0);
    for (int i = 0; i < NR; i++) pre[i] = regs[i];
    n0 = wlog_addr.size();
    run_op(1'b0, 1'b1, base, -1, cyc, to, bd, rw, rd, us);
    exp_cyc = 1 + NX * (lat_in + 2);
    checks++;
    if (to || cyc !== exp_cyc) begin
      errors++; $display("FAIL restore_latency base=%h: cycles=%0d timeout=%b, required %0d", base, cyc, to, exp_cyc);
    end
    checks++;
    if (rw !== NX || bd !== 0 || us !== 0 || wlog_addr.size() !== n0) begin
      errors++; $display("FAIL restore_signals: regwrites=%0d busy_drops=%0d unstable=%0d memwrites=%0d, required %0d 0 0 0",
                         rw, bd, us, wlog_addr.size() - n0, NX);
    end
    for (int i = 0; i < NR; i++) begin
      exp_v = (i >= FIRST) ? init_mem[i] : pre[i];
      checks++;
      if (regs[i] !== exp_v) begin
        errors++; $display("FAIL restore_r%0d: got %h, required %h", i, regs[i], exp_v);
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL restore_done_pulse: Done=%b Busy=%b, required 0 0", Done, Busy);
    end
  endtask

  task automatic test_both_start();
    int cyc, bd, rw, rd, us, n0;
    bit to;
    lat = 1;
    load_reg_file(1'b1, 16'h0000);
    n0 = wlog_addr.size();
    run_op(1'b1, 1'b1, 16'h0500, 3, cyc, to, bd, rw, rd, us);
    checks++;
    if (to || rd !== 0 || rw !== 0 || wlog_addr.size() - n0 !== NX) begin
      errors++; $display("FAIL both_start_save_wins: timeout=%b reads=%0d regwrites=%0d writes=%0d, required 0 0 0 %0d",
                         to, rd, rw, wlog_addr.size() - n0, NX);
    end
    checks++;
    if (bd !== 0 || cyc !== 1 + 2 * NX) begin
      errors++; $display("FAIL both_start_busy: busy_drops=%0d cycles=%0d, required 0 %0d", bd, cyc, 1 + 2 * NX);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (Busy !== 1'b0 || Mem_req !== 1'b0) begin
      errors++; $display("FAIL ignored_restore: Busy=%b Mem_req=%b, required 0 0", Busy, Mem_req);
    end
  endtask

  task automatic test_reset_mid_restore();
    int n, cyc, bd, rw, rd, us;
    bit to;
    logic [15:0] base;
    logic [15:0] exp_v;
    base = 16'($urandom) & 16'hFFFE;
    lat = 0;
    load_reg_file(1'b0, 16'h5500);
    load_memory(base, 1'b1, 16'h0000);
    Start_restore = 1'b1; Base_addr = base;
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(posedge CLK); #1;
      Start_restore = 1'b0;
      if (Reg_Write) n++;
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL midreset_progress: writes=%0d, required 3", n);
    end
    @(posedge CLK); #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Reg_Write, Mem_req, Mem_we, Reg_rd_addr, Reg_wr_addr, Reg_wr_data,
         Mem_addr, Mem_wdata} !== 59'd0) begin
      errors++; $display("FAIL midreset_async: Busy=%b Reg_Write=%b Mem_req=%b Mem_addr=%h, required all 0",
                         Busy, Reg_Write, Mem_req, Mem_addr);
    end
    repeat (2) @(posedge CLK);
    for (int i = 0; i < NR; i++) begin
      exp_v = (i >= FIRST && i < FIRST + 3) ? init_mem[i] : 16'h5500 + 16'(i);
      checks++;
      if (regs[i] !== exp_v) begin
        errors++; $display("FAIL midreset_r%0d: got %h, required %h", i, regs[i], exp_v);
      end
    end
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK); #1;
    run_op(1'b0, 1'b1, base, -1, cyc, to, bd, rw, rd, us);
    checks++;
    if (to || rw !== NX) begin
      errors++; $display("FAIL midreset_rerun: timeout=%b regwrites=%0d, required 0 %0d", to, rw, NX);
    end
    for (int i = FIRST; i < NR; i++) begin
      checks++;
      if (regs[i] !== init_mem[i]) begin
        errors++; $display("FAIL rerun_r%0d: got %h, required %h", i, regs[i], init_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin regs[i] = 16'h0000; init_regs[i] = 16'h0000; init_mem[i] = 16'h0000; end
    test_reset();
    test_save(16'h0200, 0, 1'b0);
    test_restore(16'h0300, 2, 1'b0);
    test_both_start();
    test_save(16'hFFFC, 0, 1'b1);
    test_save(16'($urandom), int'($urandom_range(1, 3)), 1'b1);
    test_restore(16'($urandom), int'($urandom_range(0, 3)), 1'b1);
    test_reset_mid_restore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
